mrv32_mem_arbiter: RTL

- Shares one memory port between the instruction-fetch requester (port I) and the load/store unit (port D) of the MRV32 core.
- Holds at most one outstanding transaction and returns each response to the requester that issued it.
- Uses fixed priority to D, with a bounded-starvation guarantee for I.
- Sits between the core's fetch/LSU front-ends and the unified memory of MEM_BYTES bytes.

---
 rtl/mrv32_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mrv32_mem_arbiter.sv
// mrv32_mem_arbiter
// Shares the single unified memory port between instruction fetch (port I)
// and the load/store unit (port D). One transaction is in flight at a time,
// D has fixed priority, and I is guaranteed a grant after at most
// MAX_D_BURST consecutive D grants while it is waiting.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction in flight; grant logic active, readies live
// REQ   | mem_req_valid held high with stable fields until handshake
// RSP   | handshake done; waiting for the single mem_rsp_valid pulse
module mrv32_mem_arbiter #(
    parameter int AW          = 20,
    parameter int XLEN        = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [AW-1:0]   i_req_addr,
    output logic            i_rsp_valid,
    output logic [XLEN-1:0] i_rsp_rdata,

    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [AW-1:0]   d_req_addr,
    input  logic            d_req_we,
    input  logic [3:0]      d_req_wstrb,
    input  logic [XLEN-1:0] d_req_wdata,
    output logic            d_rsp_valid,
    output logic [XLEN-1:0] d_rsp_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_we,
    output logic [3:0]      mem_req_wstrb,
    output logic [XLEN-1:0] mem_req_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata
);

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] D_CNT_MAX  = 4'(MAX_D_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t     state;
    logic       owner;      // 1 = transaction belongs to D, 0 = I
    logic [3:0] d_cnt;
    logic       gnt_i;
    logic       gnt_d;

    // Fixed priority to D unless I has waited through a full D burst.
    // Readies are held low while reset is asserted so no request is
    // acknowledged in a cycle whose acceptance would be discarded.
    always_comb begin
        gnt_d       = d_req_valid && !(i_req_valid && (d_cnt == D_CNT_MAX));
        gnt_i       = i_req_valid && !gnt_d;
        i_req_ready = rst_n && (state == IDLE) && gnt_i;
        d_req_ready = rst_n && (state == IDLE) && gnt_d;
    end

    // Starvation counter: counts consecutive D grants while I is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_cnt <= 4'd0;
        end else if (!i_req_valid) begin
            d_cnt <= 4'd0;
        end else if ((state == IDLE) && gnt_i) begin
            d_cnt <= 4'd0;
        end else if ((state == IDLE) && gnt_d && (d_cnt != D_CNT_MAX)) begin
            d_cnt <= d_cnt + 4'd1;
        end
    end

    // Transaction FSM with registered memory request and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wstrb <= WSTRB_NONE;
            mem_req_wdata <= '0;
            i_rsp_valid   <= 1'b0;
            i_rsp_rdata   <= '0;
            d_rsp_valid   <= 1'b0;
            d_rsp_rdata   <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_d) begin
                        owner         <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= d_req_addr;
                        mem_req_we    <= d_req_we;
                        // Loads never drive byte enables, whatever the LSU left on the bus.
                        mem_req_wstrb <= d_req_we ? d_req_wstrb : WSTRB_NONE;
                        mem_req_wdata <= d_req_wdata;
                        state         <= REQ;
                    end else if (gnt_i) begin
                        owner         <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= i_req_addr;
                        mem_req_we    <= 1'b0;
                        mem_req_wstrb <= WSTRB_NONE;
                        mem_req_wdata <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        if (owner) begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_rdata <= mem_rsp_rdata;
                        end else begin
                            i_rsp_valid <= 1'b1;
                            i_rsp_rdata <= mem_rsp_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
